// File: rtl/dmem_access_ctrl.sv
// Purpose : MEM-stage sequencer turning MemRead/MemWrite into a held req/ready access to a variable-latency data memory.
// Latency : ready on ACCESS cycle k (k>=1) -> stall high k+1 cycles, access_done/read_data in the following cycle.
// Backpr. : stall freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB until the memory answers or TIMEOUT ACCESS cycles elapse.
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   mem_read, mem_write    : EX/MEM load/store controls (store wins if both set)
//   addr, wdata            : EX/MEM byte address and store data
//   dmem_ready, dmem_rdata : memory acknowledge and read data
//   dmem_req, dmem_we      : registered request / write enable to memory
//   dmem_addr, dmem_wdata  : registered word-aligned address and store data
//   stall                  : combinational pipeline freeze
//   read_data              : registered load result for MEM/WB
//   access_done            : one-cycle pulse on the release (DONE) cycle
//   timeout_err            : sticky timeout flag, cleared only by reset
module dmem_access_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        stall,
   output logic [31:0] read_data,
   output logic        access_done,
   output logic        timeout_err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   // Value of wait_cnt on the last ACCESS cycle before the access is abandoned.
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_op;

   // Byte-lane bits are dropped: the memory is addressed by word.
   logic             unused_addr_lsbs;
   assign unused_addr_lsbs = ^addr[1:0];

   assign mem_op = mem_read | mem_write;

   // The stall must rise in the same cycle the access is first seen in IDLE,
   // before any registered state has reacted, hence combinational.
   assign stall = !reset & (((state == S_IDLE) & mem_op) | (state == S_ACCESS));

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= 32'd0;
         dmem_wdata  <= 32'd0;
         read_data   <= 32'd0;
         access_done <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         access_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mem_op) begin
                  state      <= S_ACCESS;
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write;
                  dmem_addr  <= {addr[31:2], 2'b00};
                  dmem_wdata <= wdata;
                  wait_cnt   <= '0;
               end
            end
            S_ACCESS: begin
               // A response on the final wait cycle still counts as success.
               if (dmem_ready) begin
                  if (!dmem_we) begin
                     read_data <= dmem_rdata;
                  end
                  dmem_req    <= 1'b0;
                  access_done <= 1'b1;
                  state       <= S_DONE;
               end else if (wait_cnt == LAST_WAIT) begin
                  timeout_err <= 1'b1;
                  read_data   <= 32'd0;
                  dmem_req    <= 1'b0;
                  access_done <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DONE: begin
               // EX/MEM still holds the finished instruction here; skip it.
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 5;

   logic        clk;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        stall;
   logic [31:0] read_data;
   logic        access_done;
   logic        timeout_err;

   dmem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .addr        (addr),
      .wdata       (wdata),
      .dmem_ready  (dmem_ready),
      .dmem_rdata  (dmem_rdata),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .stall       (stall),
      .read_data   (read_data),
      .access_done (access_done),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] rd;
      logic        err;
      int          stall_n;
      int          req_n;
   } exp_t;

   exp_t        sb[$];
   int          lat_q[$];
   logic [31:0] rdat_q[$];

   int total = 0;
   int bad   = 0;
   bit abort = 0;

   // Reference model state: last load result and sticky error.
   logic [31:0] m_rd  = 32'd0;
   logic        m_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: answers on the lat-th cycle of each request.
   initial begin : responder
      int cnt;
      int cur_lat;
      logic [31:0] cur_rdat;
      cnt = 0;
      cur_lat = 1000;
      cur_rdat = 32'd0;
      dmem_ready = 1'b0;
      dmem_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (dmem_req) begin
            if (cnt == 0) begin
               if (lat_q.size() > 0) begin
                  cur_lat  = lat_q.pop_front();
                  cur_rdat = rdat_q.pop_front();
               end else begin
                  cur_lat  = 1000;
                  cur_rdat = 32'd0;
               end
            end
            cnt++;
            dmem_ready = (cnt == cur_lat);
            dmem_rdata = (cnt == cur_lat) ? cur_rdat : $urandom;
         end else begin
            cnt = 0;
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
         end
      end
   end

   // Monitor: measures each access and checks it against the scoreboard on access_done.
   initial begin : monitor
      int stall_cnt;
      int req_cnt;
      logic [31:0] c_addr;
      logic [31:0] c_wdata;
      logic        c_we;
      bit          hold_bad;
      bit          prev_done;
      exp_t        e;
      stall_cnt = 0;
      req_cnt = 0;
      c_addr = 32'd0;
      c_wdata = 32'd0;
      c_we = 1'b0;
      hold_bad = 0;
      prev_done = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_cnt = 0;
            req_cnt = 0;
            hold_bad = 0;
            prev_done = 0;
         end else begin
            if (prev_done) chk("done_pulse_width", {31'd0, access_done}, 32'd0);
            if (stall) stall_cnt++;
            if (dmem_req) begin
               req_cnt++;
               if (req_cnt == 1) begin
                  c_addr = dmem_addr;
                  c_wdata = dmem_wdata;
                  c_we = dmem_we;
               end else if (dmem_addr !== c_addr || dmem_wdata !== c_wdata || dmem_we !== c_we) begin
                  hold_bad = 1;
               end
            end
            if (access_done) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("read_data", read_data, e.rd);
                  chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.err});
                  chk("stall_cycles", 32'(stall_cnt), 32'(e.stall_n));
                  chk("req_cycles", 32'(req_cnt), 32'(e.req_n));
                  chk("dmem_addr", c_addr, e.addr);
                  chk("dmem_we", {31'd0, c_we}, {31'd0, e.we});
                  if (e.we) chk("dmem_wdata", c_wdata, e.wdata);
                  chk("req_held_stable", {31'd0, hold_bad}, 32'd0);
                  chk("done_stall", {31'd0, stall}, 32'd0);
                  chk("done_req", {31'd0, dmem_req}, 32'd0);
               end
               stall_cnt = 0;
               req_cnt = 0;
               hold_bad = 0;
            end
            prev_done = access_done;
         end
      end
   end

   // Issues one access in the IDLE cycle after an optional idle gap, returns at DONE.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input int lat,
                            input logic [31:0] rdat, input int gap);
      exp_t e;
      int   k;
      bit   seen;
      if (abort) return;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
         mem_read = 1'b0;
         mem_write = 1'b0;
         addr = $urandom;
         wdata = $urandom;
      end
      k = (lat <= TIMEOUT) ? lat : TIMEOUT;
      if (lat <= TIMEOUT) begin
         if (!wr) m_rd = rdat;
      end else begin
         m_rd = 32'd0;
         m_err = 1'b1;
      end
      e.addr = a & 32'hFFFF_FFFC;
      e.wdata = wd;
      e.we = wr;
      e.rd = m_rd;
      e.err = m_err;
      e.stall_n = k + 1;
      e.req_n = k;
      sb.push_back(e);
      lat_q.push_back(lat);
      rdat_q.push_back(rdat);
      @(posedge clk);
      #1;
      mem_read = rd;
      mem_write = wr;
      addr = a;
      wdata = wd;
      seen = 0;
      for (int c = 0; c < TIMEOUT + 10; c++) begin
         @(posedge clk);
         #1;
         if (access_done) begin
            seen = 1;
            break;
         end
         addr = $urandom;
         wdata = $urandom;
      end
      if (!seen) begin
         chk("done_wait_budget", 32'd0, 32'd1);
         abort = 1;
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int op;
      int lat;
      logic [31:0] ra;
      reset = 1'b1;
      mem_read = 1'b1;
      mem_write = 1'b0;
      addr = 32'h0000_1000;
      wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_req", {31'd0, dmem_req}, 32'd0);
      chk("reset_we", {31'd0, dmem_we}, 32'd0);
      chk("reset_addr", dmem_addr, 32'd0);
      chk("reset_wdata", dmem_wdata, 32'd0);
      chk("reset_read_data", read_data, 32'd0);
      chk("reset_done", {31'd0, access_done}, 32'd0);
      chk("reset_err", {31'd0, timeout_err}, 32'd0);
      reset = 1'b0;
      mem_read = 1'b0;

      do_access(1, 0, 32'h0000_1006, $urandom, 2, 32'hCAFE_F00D, 0);
      do_access(0, 1, 32'h0000_0020, 32'h1234_5678, 1, $urandom, 1);
      do_access(1, 0, $urandom, $urandom, TIMEOUT, 32'hA5A5_A5A5, 1);
      do_access(1, 0, $urandom, $urandom, 3, $urandom, 0);
      do_access(1, 1, 32'h0000_0444, 32'hDEAD_BEEF, 2, $urandom, 0);
      do_access(1, 0, $urandom, $urandom, TIMEOUT + 4, $urandom, 1);
      do_access(1, 0, $urandom, $urandom, 2, 32'h0BAD_CAFE, 0);

      // Reset in the third ACCESS cycle.
      if (!abort) begin
         @(posedge clk);
         #1;
         mem_read = 1'b1;
         mem_write = 1'b0;
         addr = $urandom;
         lat_q.push_back(1000);
         rdat_q.push_back(32'd0);
         repeat (3) begin
            @(posedge clk);
            #1;
         end
         chk("mid_req_active", {31'd0, dmem_req}, 32'd1);
         reset = 1'b1;
         #1;
         chk("mid_reset_stall", {31'd0, stall}, 32'd0);
         @(posedge clk);
         #1;
         reset = 1'b0;
         mem_read = 1'b0;
         #1;
         chk("post_reset_req", {31'd0, dmem_req}, 32'd0);
         chk("post_reset_addr", dmem_addr, 32'd0);
         chk("post_reset_read_data", read_data, 32'd0);
         chk("post_reset_err", {31'd0, timeout_err}, 32'd0);
         chk("post_reset_stall", {31'd0, stall}, 32'd0);
         m_rd = 32'd0;
         m_err = 1'b0;
      end
      do_access(1, 0, $urandom, $urandom, 3, 32'h7777_1111, 0);

      for (int i = 0; i < 150; i++) begin
         op = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) lat = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
         else lat = $urandom_range(1, 6);
         ra = $urandom;
         do_access(op != 1, op != 0, ra, $urandom, lat, $urandom, $urandom_range(0, 2));
      end

      @(posedge clk);
      #1;
      mem_read = 1'b0;
      mem_write = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
